// File: rtl/blk_mem_responder_if.sv
// Request/response bundle between a cache or memory port and blk_mem_responder.
// Line traffic is 256 bits wide; word traffic is 32 bits wide.
interface blk_mem_responder_if;
    logic         BlkRead;
    logic         BlkWrite;
    logic         MemRead;
    logic         MemWrite;
    logic [31:0]  address_fCPU;
    logic [255:0] block_write_in;
    logic [31:0]  data_write_in;
    logic [255:0] block_read_out;
    logic [31:0]  data_read_out;
    logic         busy;
    logic         done;

    modport master (
        output BlkRead, BlkWrite, MemRead, MemWrite,
        output address_fCPU, block_write_in, data_write_in,
        input  block_read_out, data_read_out, busy, done
    );

    modport slave (
        input  BlkRead, BlkWrite, MemRead, MemWrite,
        input  address_fCPU, block_write_in, data_write_in,
        output block_read_out, data_read_out, busy, done
    );
endinterface

// File: rtl/blk_mem_responder.sv
// Fixed-latency main-memory responder: one outstanding line or word request,
// served from a line-organised array after LATENCY cycles.
module blk_mem_responder #(
    parameter int unsigned LINE_BITS = 5,
    parameter int unsigned LATENCY   = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    blk_mem_responder_if.slave   bus
);

    localparam int unsigned LINES   = 1 << LINE_BITS;
    localparam logic [3:0]  LAT_CNT = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {REQ_BLK_WR, REQ_BLK_RD, REQ_MEM_WR, REQ_MEM_RD} req_t;

    state_t state, state_next;
    req_t   req, req_next;
    logic [3:0] cnt, cnt_next;
    logic       capture;
    logic       commit;
    logic       any_strobe;

    logic [LINE_BITS-1:0] line_q;
    logic [2:0]           word_q;
    logic [255:0]         blk_wdata_q;
    logic [31:0]          word_wdata_q;

    logic [255:0] mem [LINES];

    logic [255:0] block_read_q;
    logic [31:0]  data_read_q;
    logic         busy_q;
    logic         done_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.address_fCPU[31:LINE_BITS+5], bus.address_fCPU[1:0]};

    assign any_strobe = bus.BlkWrite | bus.BlkRead | bus.MemWrite | bus.MemRead;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        req_next   = req;
        capture    = 1'b0;
        commit     = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_strobe) begin
                    capture    = 1'b1;
                    state_next = WAIT;
                    cnt_next   = 4'd1;
                    if (bus.BlkWrite)      req_next = REQ_BLK_WR;
                    else if (bus.BlkRead)  req_next = REQ_BLK_RD;
                    else if (bus.MemWrite) req_next = REQ_MEM_WR;
                    else                   req_next = REQ_MEM_RD;
                end
            end
            WAIT: begin
                if (cnt == LAT_CNT) begin
                    state_next = DONE;
                    commit     = 1'b1;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: state_next = IDLE;
        endcase
    end

    // busy/done are registered from the next state so they line up with the FSM
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= IDLE;
            cnt          <= '0;
            req          <= REQ_MEM_RD;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            block_read_q <= '0;
            data_read_q  <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            req    <= req_next;
            busy_q <= (state_next != IDLE);
            done_q <= (state_next == DONE);
            if (commit && req == REQ_BLK_RD)
                block_read_q <= mem[line_q];
            if (commit && req == REQ_MEM_RD)
                data_read_q <= mem[line_q][{word_q, 5'b0} +: 32];
        end
    end

    always_ff @(posedge CLK) begin
        if (capture) begin
            line_q       <= bus.address_fCPU[LINE_BITS+4:5];
            word_q       <= bus.address_fCPU[4:2];
            blk_wdata_q  <= bus.block_write_in;
            word_wdata_q <= bus.data_write_in;
        end
    end

    // commit is only ever raised from WAIT, so a reset abandons the write
    always_ff @(posedge CLK) begin
        if (commit && req == REQ_BLK_WR)
            mem[line_q] <= blk_wdata_q;
        if (commit && req == REQ_MEM_WR)
            mem[line_q][{word_q, 5'b0} +: 32] <= word_wdata_q;
    end

    assign bus.block_read_out = block_read_q;
    assign bus.data_read_out  = data_read_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;

endmodule

// File: tb/tb_blk_mem_responder.sv
// Scoreboard bench for blk_mem_responder: a reference array predicts the read
// outputs after each accepted request; predictions are queued and popped on done.
module tb_blk_mem_responder;

    typedef struct {
        logic [3:0]   stb;   // {BlkWrite, BlkRead, MemWrite, MemRead}
        logic [31:0]  addr;
        logic [255:0] blk;
        logic [31:0]  word;
    } req_t;

    typedef struct {
        logic [255:0] blk;
        logic [31:0]  word;
    } exp_t;

    logic CLK;
    logic RESET;
    blk_mem_responder_if bus();

    blk_mem_responder #(.LINE_BITS(5), .LATENCY(4)) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    exp_t         exp_q[$];
    logic [255:0] ref_mem [32];
    logic [255:0] model_blk;
    logic [31:0]  model_word;
    int checks;
    int errors;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic drive_idle();
        bus.BlkWrite = 1'b0;
        bus.BlkRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.MemRead  = 1'b0;
    endtask

    task automatic drive_req(input req_t r);
        bus.BlkWrite       = r.stb[3];
        bus.BlkRead        = r.stb[2];
        bus.MemWrite       = r.stb[1];
        bus.MemRead        = r.stb[0];
        bus.address_fCPU   = r.addr;
        bus.block_write_in = r.blk;
        bus.data_write_in  = r.word;
    endtask

    // Reference model: applies the highest-priority strobe and queues the outputs it predicts
    task automatic model_apply(input req_t r);
        logic [4:0] ln;
        logic [2:0] w;
        exp_t e;
        ln = r.addr[9:5];
        w  = r.addr[4:2];
        if (r.stb[3])      ref_mem[ln] = r.blk;
        else if (r.stb[2]) model_blk = ref_mem[ln];
        else if (r.stb[1]) ref_mem[ln][{w, 5'b0} +: 32] = r.word;
        else if (r.stb[0]) model_word = ref_mem[ln][{w, 5'b0} +: 32];
        e.blk  = model_blk;
        e.word = model_word;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the FSM is back in IDLE
    task automatic run_req(input req_t r, output int lat, output logic busy_mid);
        drive_req(r);
        @(negedge CLK);
        drive_idle();
        busy_mid = bus.busy;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge CLK);
            if (bus.done === 1'b1) begin
                lat = n;
                break;
            end
        end
        @(negedge CLK);
    endtask

    function automatic logic [255:0] make_pattern(input logic [31:0] base);
        logic [255:0] p;
        for (int unsigned i = 0; i < 8; i++) p[i*32 +: 32] = base + 32'(i);
        return p;
    endfunction

    task automatic test_reset();
        RESET = 1'b1;
        drive_idle();
        bus.address_fCPU   = '0;
        bus.block_write_in = '0;
        bus.data_write_in  = '0;
        #2 RESET = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            bus.BlkWrite     = 1'($urandom_range(1, 0));
            bus.BlkRead      = 1'($urandom_range(1, 0));
            bus.MemWrite     = 1'($urandom_range(1, 0));
            bus.MemRead      = 1'($urandom_range(1, 0));
            bus.address_fCPU = $urandom;
        end
        @(negedge CLK);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.block_read_out !== 256'h0) begin errors++; $display("FAIL reset_blk got %h want 0", bus.block_read_out); end
        checks++; if (bus.data_read_out !== 32'h0) begin errors++; $display("FAIL reset_word got %h want 0", bus.data_read_out); end
        drive_idle();
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL post_reset_done got %b want 0", bus.done); end
        model_blk  = '0;
        model_word = '0;
    endtask

    task automatic run_table(input string name, input req_t r[$]);
        int lat;
        logic bm;
        exp_t e;
        foreach (r[i]) begin
            model_apply(r[i]);
            run_req(r[i], lat, bm);
            e = exp_q.pop_front();
            checks++; if (lat != 4) begin errors++; $display("FAIL %s[%0d]_latency got %0d want 4", name, i, lat); end
            checks++; if (bm !== 1'b1) begin errors++; $display("FAIL %s[%0d]_busy got %b want 1", name, i, bm); end
            checks++; if (bus.block_read_out !== e.blk) begin errors++; $display("FAIL %s[%0d]_blk got %h want %h", name, i, bus.block_read_out, e.blk); end
            checks++; if (bus.data_read_out !== e.word) begin errors++; $display("FAIL %s[%0d]_word got %h want %h", name, i, bus.data_read_out, e.word); end
        end
    endtask

    task automatic test_line_rw();
        req_t r[$];
        logic [255:0] pat;
        pat = make_pattern(32'hA5A5_0000);
        r.push_back('{4'b1000, 32'h60, pat, 32'h0});
        r.push_back('{4'b0100, 32'h60, '0, 32'h0});
        run_table("line_rw", r);
        checks++; if (bus.block_read_out !== pat) begin errors++; $display("FAIL line_rw_pattern got %h want %h", bus.block_read_out, pat); end
    endtask

    task automatic test_word_merge();
        req_t r[$];
        r.push_back('{4'b1000, 32'h40, '0, 32'h0});
        r.push_back('{4'b0010, 32'h4C, '0, 32'hDEAD_BEEF});
        r.push_back('{4'b0100, 32'h40, '0, 32'h0});
        r.push_back('{4'b0001, 32'h4C, '0, 32'h0});
        run_table("word_merge", r);
        checks++; if (bus.data_read_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_merge_final got %h want deadbeef", bus.data_read_out); end
    endtask

    task automatic test_same_cycle();
        req_t r[$];
        logic [255:0] p7;
        p7 = make_pattern(32'hC0DE_0000);
        r.push_back('{4'b1000, 32'hE0, p7, 32'h0});
        r.push_back('{4'b0110, 32'hE4, '0, 32'hFFFF_FFFF});
        r.push_back('{4'b0001, 32'hE4, '0, 32'h0});
        r.push_back('{4'b1100, 32'hE0, ~p7, 32'h0});
        r.push_back('{4'b0100, 32'hE0, '0, 32'h0});
        run_table("same_cycle", r);
    endtask

    task automatic test_busy_wrap();
        req_t r[$];
        req_t w;
        exp_t e;
        int dones;
        r.push_back('{4'b1000, 32'h0, '0, 32'h0});
        run_table("wrap_clear", r);
        w = '{4'b0010, 32'h1000, '0, 32'h1234_5678};
        model_apply(w);
        drive_req(w);
        @(negedge CLK);
        drive_idle();
        dones = 0;
        @(negedge CLK);
        bus.MemWrite      = 1'b1;
        bus.address_fCPU  = 32'h1004;
        bus.data_write_in = 32'h0BAD_0BAD;
        @(negedge CLK);
        drive_idle();
        for (int i = 0; i < 10; i++) begin
            if (bus.done === 1'b1) dones++;
            @(negedge CLK);
        end
        e = exp_q.pop_front();
        checks++; if (dones != 1) begin errors++; $display("FAIL busy_done_count got %0d want 1", dones); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_idle got %b want 0", bus.busy); end
        checks++; if (bus.data_read_out !== e.word) begin errors++; $display("FAIL busy_word got %h want %h", bus.data_read_out, e.word); end
        r.delete();
        r.push_back('{4'b0001, 32'h0000, '0, 32'h0});
        r.push_back('{4'b0001, 32'h0004, '0, 32'h0});
        run_table("wrap_read", r);
    endtask

    task automatic test_reset_mid();
        req_t r[$];
        int dones;
        logic [255:0] p5;
        p5 = make_pattern(32'h5555_0000);
        r.push_back('{4'b1000, 32'hA0, p5, 32'h0});
        r.push_back('{4'b0100, 32'hA0, '0, 32'h0});
        run_table("mid_setup", r);
        drive_req('{4'b1000, 32'hA0, ~p5, 32'h0});
        @(negedge CLK);
        drive_idle();
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.block_read_out !== 256'h0) begin errors++; $display("FAIL mid_reset_blk got %h want 0", bus.block_read_out); end
        model_blk  = '0;
        model_word = '0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done === 1'b1) dones++;
            @(negedge CLK);
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL mid_reset_done_count got %0d want 0", dones); end
        r.delete();
        r.push_back('{4'b0100, 32'hA0, '0, 32'h0});
        run_table("mid_read", r);
        checks++; if (bus.block_read_out !== p5) begin errors++; $display("FAIL mid_preserved got %h want %h", bus.block_read_out, p5); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_line_rw();
        test_word_merge();
        test_same_cycle();
        test_busy_wrap();
        test_reset_mid();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
